// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/256 encryptor, one round per cycle, on-the-fly key expansion.
// Define AES_DBG_TAP_EN to add per-round state taps read back through dbg_sel/dbg_data.
module aes_iter_core #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        data_in,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        data_out,
    output logic                busy,
    input  logic [3:0]          dbg_sel,
    output logic [127:0]        dbg_data
);
    localparam int unsigned NR = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    // Byte x of the table sits at [2047-8x -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    state_e                st_q;
    logic [3:0]            round_q;
    logic [7:0]            rcon_q, rcon_next;
    logic [127:0]          state_q, data_out_q;
    logic [KEY_BITS-1:0]   key_q, key_next;
    logic                  out_valid_q, busy_q;
    logic                  accept, rot_step;
    logic [127:0]          init_state, sub_shift, mixed, round_out, round_key, new_words;
    logic [31:0]           kw_f, nw0, nw1, nw2, nw3;

    assign in_ready   = rst_n && ((st_q == StIdle) || (st_q == StDone && out_ready));
    assign accept     = in_valid && in_ready;
    assign init_state = data_in ^ key_in[KEY_BITS-1 -: 128];

    // Next four schedule words; the top four window words are the i-Nk terms.
    always_comb begin
        kw_f = rot_step ? (sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_q, 24'h0})
                        : sub_word(key_q[31:0]);
        nw0 = key_q[KEY_BITS-1 -: 32] ^ kw_f;
        nw1 = key_q[KEY_BITS-33 -: 32] ^ nw0;
        nw2 = key_q[KEY_BITS-65 -: 32] ^ nw1;
        nw3 = key_q[KEY_BITS-97 -: 32] ^ nw2;
        new_words = {nw0, nw1, nw2, nw3};
        rcon_next = rot_step ? xtime(rcon_q) : rcon_q;
    end

    if (KEY_BITS == 256) begin : g_ks256
        // Round 1 uses the stored w4..w7; later rounds alternate Rcon and SubWord-only steps.
        assign rot_step  = ~round_q[0];
        assign round_key = (round_q == 4'd1) ? key_q[127:0] : new_words;
        assign key_next  = (round_q == 4'd1) ? key_q : {key_q[127:0], new_words};
    end else begin : g_ks128
        assign rot_step  = 1'b1;
        assign round_key = new_words;
        assign key_next  = new_words;
    end

    always_comb begin
        sub_shift = '0;
        mixed     = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_shift[127 - 8*(4*c + r) -: 8] =
                    sbox(state_q[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = mix_col(sub_shift[127 - 32*c -: 32]);
        end
        round_out = ((round_q == LAST_ROUND) ? sub_shift : mixed) ^ round_key;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= StIdle;
            round_q     <= '0;
            rcon_q      <= '0;
            state_q     <= '0;
            key_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            st_q        <= StRound;
            round_q     <= 4'd1;
            rcon_q      <= 8'h01;
            state_q     <= init_state;
            key_q       <= key_in;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            unique case (st_q)
                StRound: begin
                    state_q <= round_out;
                    key_q   <= key_next;
                    rcon_q  <= rcon_next;
                    if (round_q == LAST_ROUND) begin
                        data_out_q  <= round_out;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        st_q        <= StDone;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        st_q        <= StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign busy      = busy_q;

`ifdef AES_DBG_TAP_EN
    logic [127:0] tap_q [0:NR];
    logic [127:0] dbg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(NR); i++) tap_q[i] <= '0;
            dbg_q <= '0;
        end else begin
            if (accept) begin
                tap_q[0] <= init_state;
            end else if (st_q == StRound) begin
                tap_q[round_q] <= round_out;
            end
            dbg_q <= (dbg_sel <= LAST_ROUND) ? tap_q[dbg_sel] : '0;
        end
    end

    assign dbg_data = dbg_q;
`else
    logic unused_dbg_sel;
    assign unused_dbg_sel = ^dbg_sel;
    assign dbg_data       = '0;
`endif

endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboarded bench for aes_iter_core: one AES-128 and one AES-256 instance against a
// GF(2^8)-based reference model, with known-answer, backpressure, abort and random traffic.
module tb_aes_iter_core;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   dbg_sel;

    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [127:0] data_in_a, key_in_a, data_out_a, dbg_data_a;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [127:0] data_in_b, data_out_b, dbg_data_b;
    logic [255:0] key_in_b;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] q_a[$];
    logic [127:0] q_b[$];
    logic [7:0]   sbox_m [256];

    always #5 clk = ~clk;

    aes_iter_core #(.KEY_BITS(128)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .data_in(data_in_a), .key_in(key_in_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .data_out(data_out_a), .busy(busy_a),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data_a)
    );

    aes_iter_core #(.KEY_BITS(256)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .data_in(data_in_b), .key_in(key_in_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .data_out(data_out_b), .busy(busy_b),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data_b)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // key holds the cipher key left-aligned (AES-128 key in [255:128]).
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key,
                                             input int nk);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  temp;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                temp = subw(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8] ^ w[b/4][31 - 8*(b%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int b = 0; b < 16; b++) t[b] = sbox_m[s[b]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) s[rw + 4*c] = t[rw + 4*((c + rw) % 4)];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31 - 8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : mon
        logic [127:0] e;
        if (rst_n && out_valid_a && out_ready_a) begin
            if (q_a.size() == 0) check("unexpected_out_a", data_out_a, 128'hx);
            else begin
                e = q_a.pop_front();
                check("out_a", data_out_a, e);
            end
        end
        if (rst_n && out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) check("unexpected_out_b", data_out_b, 128'hx);
            else begin
                e = q_b.pop_front();
                check("out_b", data_out_b, e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input bit big, input logic [127:0] pt, input logic [255:0] key,
                        input logic [127:0] exp);
        bit ok;
        ok = 1'b0;
        if (big) begin
            in_valid_b = 1'b1; data_in_b = pt; key_in_b = key;
        end else begin
            in_valid_a = 1'b1; data_in_a = pt; key_in_a = key[255:128];
        end
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = big ? in_ready_b : in_ready_a;
        end
        if (!ok) begin
            check(big ? "accept_timeout_b" : "accept_timeout_a", 128'd0, 128'd1);
        end else begin
            if (big) q_b.push_back(exp);
            else q_a.push_back(exp);
            @(posedge clk);
            #1;
        end
        // Scramble inputs after the accepting edge; the core must ignore them.
        if (big) begin
            in_valid_b = 1'b0; data_in_b = rand128(); key_in_b = {rand128(), rand128()};
        end else begin
            in_valid_a = 1'b0; data_in_a = rand128(); key_in_a = rand128();
        end
    endtask

    task automatic wait_out(input bit big, input int exp_lat, input string name);
        int lat;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk);
            #1;
`ifndef AES_DBG_TAP_EN
            check("dbg_zero_a", dbg_data_a, 128'h0);
            check("dbg_zero_b", dbg_data_b, 128'h0);
            dbg_sel = 4'($urandom);
`endif
            if (big ? out_valid_b : out_valid_a) lat = k;
        end
        check(name, 128'(lat), 128'(exp_lat));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] pa, pb, ea, eb;
        logic [255:0] ka, kb;
        build_sbox();
        rst_n = 1'b1;
        dbg_sel = 4'd0;
        in_valid_a = 1'b0; data_in_a = '0; key_in_a = '0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; data_in_b = '0; key_in_b = '0; out_ready_b = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid_a, 128'd0);
        check("rst_busy", busy_a, 128'd0);
        check("rst_data_out", data_out_a, 128'd0);
        check("rst_dbg_data", dbg_data_a, 128'd0);
        check("rst_out_valid_b", out_valid_b, 128'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready_a, 128'd1);
        check("rst_in_ready_b", in_ready_b, 128'd1);

        // Known answers
        send(0, 128'h00112233445566778899aabbccddeeff,
             {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
             128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("busy_in_round", busy_a, 128'd1);
        check("in_ready_in_round", in_ready_a, 128'd0);
        wait_out(0, 10, "lat_kat128");

        send(0, 128'h3243f6a8885a308d313198a2e0370734,
             {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
             128'h3925841d02dc09fbdc118597196a0b32);
        wait_out(0, 10, "lat_fips128");
`ifdef AES_DBG_TAP_EN
        dbg_sel = 4'd0;
        @(posedge clk); #1;
        check("dbg_tap0", dbg_data_a, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        dbg_sel = 4'd10;
        @(posedge clk); #1;
        check("dbg_tap10", dbg_data_a, 128'h3925841d02dc09fbdc118597196a0b32);
        dbg_sel = 4'd11;
        @(posedge clk); #1;
        check("dbg_sel_over_nr", dbg_data_a, 128'h0);
`endif

        send(1, 128'h00112233445566778899aabbccddeeff,
             256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
             128'h8ea2b7ca516745bfeafc49904b496089);
        wait_out(1, 14, "lat_kat256");

        // Backpressure and same-edge handoff
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        pa = rand128(); ka = {rand128(), 128'h0};
        ea = aes_ref(pa, ka, 4);
        send(0, pa, ka, ea);
        wait_out(0, 10, "lat_bp_first");
        pb = rand128(); kb = {rand128(), 128'h0};
        eb = aes_ref(pb, kb, 4);
        in_valid_a = 1'b1; data_in_a = pb; key_in_a = kb[255:128];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 5 == 0) begin
                check("bp_in_ready", in_ready_a, 128'd0);
                check("bp_out_valid", out_valid_a, 128'd1);
            end
            if (data_out_a !== ea) check("bp_data_stable", data_out_a, ea);
        end
        check("bp_data_held", data_out_a, ea);
        @(posedge clk); #1;
        out_ready_a = 1'b1;
        send(0, pb, kb, eb);
        wait_out(0, 10, "lat_handoff");

        // Abort at round 5
        pa = rand128(); ka = {rand128(), 128'h0};
        send(0, pa, ka, aes_ref(pa, ka, 4));
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy_pre", busy_a, 128'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_a, 128'd0);
        check("abort_out_valid", out_valid_a, 128'd0);
        check("abort_data_out", data_out_a, 128'd0);
        q_a.delete();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 128'h0, 256'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        wait_out(0, 10, "lat_zero128");

        // Random traffic with random output backpressure on both cores
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    pa = rand128(); ka = {rand128(), 128'h0};
                    send(0, pa, ka, aes_ref(pa, ka, 4));
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    pb = rand128(); kb = {rand128(), rand128()};
                    send(1, pb, kb, aes_ref(pb, kb, 8));
                end
            end
            begin
                repeat (300) begin
                    @(posedge clk); #1;
                    out_ready_a = 1'($urandom);
                    out_ready_b = 1'($urandom);
                end
                out_ready_a = 1'b1;
                out_ready_b = 1'b1;
            end
        join

        for (int k = 0; k < 2000 && (q_a.size() != 0 || q_b.size() != 0); k++) @(posedge clk);
        check("drain_a", 128'(q_a.size()), 128'd0);
        check("drain_b", 128'(q_b.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
